cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle.sv | 148 ++++++++++++++
 tb/tb_cpu_multicycle.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: two-cycle-minimum register-file core
// FETCH/EXEC/HALT sequencer, ALU flags and debug read port
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREG = 4,
  parameter int PC_W = 8,
  localparam int RA_W = $clog2(NREG),
  localparam int IW = 4 + 3*RA_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IW-1:0]     imem_data,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              zero,
  output logic              carry,
  output logic              done,
  input  logic [RA_W-1:0]   dbg_ra,
  output logic [DATA_W-1:0] dbg_rd
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JNZ = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state, nstate;

  logic [PC_W-1:0]   pc, pc_nxt;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] rf [NREG];

  logic [3:0]        op;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0] a, b, res;
  logic              cout, wr, arith;

  assign op  = ir[IW-1 -: 4];
  assign rd  = ir[3*RA_W-1 -: RA_W];
  assign rs1 = ir[2*RA_W-1 -: RA_W];
  assign rs2 = ir[RA_W-1:0];

  assign dbg_rd = rf[dbg_ra];

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nstate;
  end

  // next-state: ack only advances FETCH; HALT is sticky
  always_comb begin
    nstate = state;
    unique case (1'b1)
      state == FETCH: if (imem_ack) nstate = EXEC;
      state == EXEC:  nstate = (op == OP_HLT) ? HALT : FETCH;
      state == HALT:  nstate = HALT;
      default:        nstate = FETCH;
    endcase
  end

  // fetch handshake and halt status
  always_comb begin
    imem_req  = (state == FETCH) && !reset;
    imem_addr = pc;
    done      = (state == HALT);
  end

  // ALU, write-enable and next-PC for the latched instruction
  always_comb begin
    a      = rf[rs1];
    b      = rf[rs2];
    res    = '0;
    cout   = 1'b0;
    wr     = 1'b1;
    arith  = 1'b0;
    pc_nxt = pc + PC_W'(1);
    case (op)
      OP_ADD: begin
        {cout, res} = {1'b0, a} + {1'b0, b};
        arith = 1'b1;
      end
      OP_SUB: begin
        {cout, res} = {1'b0, a} - {1'b0, b};
        arith = 1'b1;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: res = a << 1;
      OP_SHR: res = a >> 1;
      OP_MOV: res = a;
      OP_LDI: res = DATA_W'({rs1, rs2});
      OP_JNZ: begin
        wr = 1'b0;
        if (a != '0) pc_nxt = pc + PC_W'($signed({rd, rs2}));
      end
      OP_HLT: begin
        wr = 1'b0;
        pc_nxt = pc;
      end
      default: wr = 1'b0;
    endcase
  end

  // datapath state: IR on ack edge, commit at end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      y_valid <= 1'b0;
      if (state == FETCH && imem_ack) ir <= imem_data;
      if (state == EXEC) begin
        pc <= pc_nxt;
        if (wr) begin
          rf[rd]  <= res;
          y       <= res;
          zero    <= (res == '0);
          y_valid <= 1'b1;
          if (arith) carry <= cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed + random programs
// checked against an instruction-level model
module tb_cpu_multicycle;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [9:0] imem_data;
  logic [7:0] y;
  logic       y_valid, zero, carry, done;
  logic [1:0] dbg_ra;
  logic [7:0] dbg_rd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [9:0] mem [256];
  int mr [4];
  int mp, my;
  bit mz, mc, mv, mh;

  cpu_multicycle dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .y(y), .y_valid(y_valid), .zero(zero),
    .carry(carry), .done(done),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] enc(input int op, input int rd,
                                     input int s1, input int s2);
    enc = {4'(op), 2'(rd), 2'(s1), 2'(s2)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mr[i] = 0;
    mp = 0; my = 0;
    mz = 0; mc = 0; mv = 0; mh = 0;
  endtask

  task automatic model_exec(input logic [9:0] ins);
    int op, rd, s1, s2, a, b, r, off;
    op = int'(ins[9:6]); rd = int'(ins[5:4]);
    s1 = int'(ins[3:2]); s2 = int'(ins[1:0]);
    a = mr[s1]; b = mr[s2]; r = 0;
    mv = 0;
    if (op <= 8) begin
      case (op)
        0: begin r = a + b; mc = (r > 255); end
        1: begin r = a - b; mc = (a < b); end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = a * 2;
        6: r = a / 2;
        7: r = a;
        default: r = s1 * 4 + s2;
      endcase
      r = r & 255;
      mr[rd] = r; my = r; mz = (r == 0); mv = 1;
      mp = (mp + 1) % 256;
    end else if (op == 9) begin
      off = rd * 4 + s2;
      if (off >= 8) off -= 16;
      mp = (a != 0) ? (mp + off + 256) % 256 : (mp + 1) % 256;
    end else if (op == 15) begin
      mh = 1;
    end else begin
      mp = (mp + 1) % 256;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".y"}, y, my);
    chk({tag, ".y_valid"}, y_valid, mv);
    chk({tag, ".zero"}, zero, mz);
    chk({tag, ".carry"}, carry, mc);
    chk({tag, ".done"}, done, mh);
    for (int i = 0; i < 4; i++) begin
      dbg_ra = 2'(i);
      #1 chk($sformatf("%s.r%0d", tag, i), dbg_rd, mr[i]);
    end
  endtask

  // starts and ends at a negedge in a FETCH cycle
  task automatic do_instr(input int dly);
    logic [9:0] ins;
    ins = mem[mp];
    for (int i = 0; i <= dly; i++) begin
      chk("fetch.req", imem_req, 1);
      chk("fetch.addr", imem_addr, mp);
      if (i > 0) chk("stall.y_valid", y_valid, 0);
      imem_ack = (i == dly);
      imem_data = imem_ack ? ins : 10'($urandom);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    imem_data = 10'($urandom);
    chk("exec.req", imem_req, 0);
    @(negedge clk);
    model_exec(ins);
    chk_state("exec");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    #1 chk("rst.req", imem_req, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_state("rst");
    chk("rst.addr", imem_addr, 0);
  endtask

  initial begin
    int c0, op;
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_data = '0;
    dbg_ra = '0;
    for (int i = 0; i < 256; i++) mem[i] = enc(10, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // add: 9 + 7
    mem[0] = enc(8, 1, 2, 1);
    mem[1] = enc(8, 2, 1, 3);
    mem[2] = enc(0, 3, 1, 2);
    c0 = cyc;
    for (int i = 0; i < 3; i++) do_instr(0);
    chk("add.cycles", cyc - c0, 6);
    chk("add.y", y, 8'h10);
    chk("add.carry", carry, 0);

    // same program with 3-cycle fetch latency
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 3; i++) do_instr(3);
    chk("slow.cycles", cyc - c0, 15);
    chk("slow.y", y, 8'h10);

    // sub with borrow, then xor self
    do_reset();
    mem[0] = enc(8, 1, 1, 3);
    mem[1] = enc(8, 2, 2, 1);
    mem[2] = enc(1, 3, 1, 2);
    mem[3] = enc(4, 3, 3, 3);
    for (int i = 0; i < 3; i++) do_instr(0);
    chk("sub.y", y, 8'hfe);
    chk("sub.carry", carry, 1);
    do_instr(0);
    chk("xor.zero", zero, 1);
    chk("xor.carry", carry, 1);

    // countdown loop, then NOP and HALT
    do_reset();
    mem[0] = enc(8, 1, 0, 3);
    mem[1] = enc(8, 2, 0, 1);
    mem[2] = enc(1, 1, 1, 2);
    mem[3] = enc(9, 3, 1, 3);
    mem[4] = enc(10, 0, 0, 0);
    mem[5] = enc(15, 0, 0, 0);
    for (int i = 0; i < 8; i++) do_instr(0);
    chk("loop.addr", imem_addr, 4);
    dbg_ra = 2'd1;
    #1 chk("loop.r1", dbg_rd, 0);
    do_instr(0);
    do_instr(0);
    chk("halt.done", done, 1);
    for (int i = 0; i < 6; i++) begin
      chk("halt.req", imem_req, 0);
      chk("halt.addr", imem_addr, 5);
      imem_ack = 1'($urandom);
      imem_data = enc(8, 0, 3, 3);
      @(negedge clk);
      chk_state("halt");
    end
    do_reset();
    chk("unhalt.done", done, 0);

    // random programs with random fetch latency
    for (int i = 0; i < 256; i++) begin
      op = int'($urandom_range(0, 15));
      if (op == 15) op = 10;
      mem[i] = enc(op, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 80; i++) do_instr(int'($urandom_range(0, 2)));

    // reset coinciding with an ack discards the fetch
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_data = enc(8, 0, 3, 3);
    #1 chk("rstack.req", imem_req, 0);
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    chk_state("rstack");
    chk("rstack.addr", imem_addr, 0);
    @(negedge clk);
    chk_state("rstack2");
    chk("rstack2.addr", imem_addr, 0);

    for (int i = 0; i < 80; i++) do_instr(int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
